// File: rtl/dmem_dump_arbiter_if.sv
// Bus bundle between the datapath MEM stage, the dump consumer, dmem and the
// arbiter. The arbiter uses the slave view; the surrounding system uses master.
// DMEM_ARB_ALIGN_CHK_EN adds the align_err flag to the bundle.
interface dmem_dump_arbiter_if #(
  parameter int N  = 64,
  parameter int AW = 6
);
  logic [N-1:0]  cpu_addr;
  logic [N-1:0]  cpu_writeData;
  logic          cpu_writeEnable;
  logic          cpu_readEnable;
  logic [N-1:0]  cpu_readData;
  logic          cpu_stall;
  logic          dump_req;
  logic          dump_ready;
  logic          dump_valid;
  logic [AW-1:0] dump_addr;
  logic [N-1:0]  dump_data;
  logic          dump_done;
  logic [AW-1:0] mem_address;
  logic [N-1:0]  mem_writeData;
  logic          mem_memWrite;
  logic          mem_memRead;
  logic [N-1:0]  mem_readData;
`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic          align_err;
`endif

  modport slave (
    input  cpu_addr, cpu_writeData, cpu_writeEnable, cpu_readEnable,
    input  dump_req, dump_ready, mem_readData,
    output cpu_readData, cpu_stall, dump_valid, dump_addr, dump_data, dump_done,
    output mem_address, mem_writeData, mem_memWrite, mem_memRead
`ifdef DMEM_ARB_ALIGN_CHK_EN
    , output align_err
`endif
  );

  modport master (
    output cpu_addr, cpu_writeData, cpu_writeEnable, cpu_readEnable,
    output dump_req, dump_ready, mem_readData,
    input  cpu_readData, cpu_stall, dump_valid, dump_addr, dump_data, dump_done,
    input  mem_address, mem_writeData, mem_memWrite, mem_memRead
`ifdef DMEM_ARB_ALIGN_CHK_EN
    , input align_err
`endif
  );
endinterface

// File: rtl/dmem_dump_arbiter.sv
// dmem_dump_arbiter: shares the single dmem port between the CPU MEM stage and
// a sequential dump scanner. A rising edge on dump_req stalls the pipeline,
// streams all DEPTH words over valid/ready, pulses dump_done, then hands the
// port back to the CPU.
// Optional: define DMEM_ARB_ALIGN_CHK_EN to add a sticky align_err flag that
// blocks misaligned or out-of-range CPU accesses.
module dmem_dump_arbiter #(
  parameter int N     = 64,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input logic                clk,
  input logic                reset,
  dmem_dump_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          req_q;
  logic          req_edge;
  logic          cpu_wr_ok;
  logic          cpu_rd_zero;

  logic [N-1:0]  cpu_readData;
  logic          cpu_stall;
  logic          dump_valid;
  logic [AW-1:0] dump_addr;
  logic [N-1:0]  dump_data;
  logic          dump_done;
  logic [AW-1:0] mem_address;
  logic [N-1:0]  mem_writeData;
  logic          mem_memWrite;
  logic          mem_memRead;

  // Only a fresh 0->1 transition starts a scan; a level held high does not.
  assign req_edge = bus.dump_req & ~req_q;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  localparam logic [N-1:0] ADDR_MAX = N'(DEPTH * 8 - 1);

  logic bad_addr;
  logic align_err_q;

  assign bad_addr    = (bus.cpu_addr[2:0] != 3'd0) || (bus.cpu_addr > ADDR_MAX);
  assign cpu_wr_ok   = ~bad_addr;
  assign cpu_rd_zero = bad_addr & bus.cpu_readEnable;

  // Sticky flag: any bad CPU access seen while the CPU owns the port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      align_err_q <= 1'b0;
    else if (state == IDLE && bad_addr && (bus.cpu_writeEnable || bus.cpu_readEnable))
      align_err_q <= 1'b1;
  end

  assign bus.align_err = align_err_q;
`else
  // Byte-offset and high address bits carry no meaning without the check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.cpu_addr[N-1:AW+3], bus.cpu_addr[2:0]};
  assign cpu_wr_ok        = 1'b1;
  assign cpu_rd_zero      = 1'b0;
`endif

  // State, scan counter and dump_req edge register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      req_q <= bus.dump_req;
    end
  end

  // Next-state logic and steering of the memory port
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cpu_readData  = bus.mem_readData;
    cpu_stall     = 1'b0;
    dump_valid    = 1'b0;
    dump_addr     = '0;
    dump_data     = '0;
    dump_done     = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    mem_memWrite  = 1'b0;
    mem_memRead   = 1'b0;
    case (state)
      IDLE: begin
        // The CPU access in the request cycle still completes.
        mem_address   = bus.cpu_addr[AW+2:3];
        mem_writeData = bus.cpu_writeData;
        mem_memWrite  = bus.cpu_writeEnable & cpu_wr_ok;
        mem_memRead   = bus.cpu_readEnable;
        if (cpu_rd_zero)
          cpu_readData = '0;
        if (req_edge)
          state_nxt = SCAN;
      end
      SCAN: begin
        cpu_stall   = 1'b1;
        mem_memRead = 1'b1;
        mem_address = cnt;
        dump_addr   = cnt;
        dump_data   = bus.mem_readData;
        dump_valid  = 1'b1;
        if (bus.dump_ready) begin
          if (cnt == LAST_IDX) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + AW'(1);
          end
        end
      end
      DONE: begin
        cpu_stall = 1'b1;
        dump_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // While reset is held the block presents a quiet port; load data still flows.
    if (!reset) begin
      cpu_readData  = bus.mem_readData;
      cpu_stall     = 1'b0;
      dump_valid    = 1'b0;
      dump_addr     = '0;
      dump_data     = '0;
      dump_done     = 1'b0;
      mem_address   = '0;
      mem_writeData = '0;
      mem_memWrite  = 1'b0;
      mem_memRead   = 1'b0;
    end
  end

  assign bus.cpu_readData  = cpu_readData;
  assign bus.cpu_stall     = cpu_stall;
  assign bus.dump_valid    = dump_valid;
  assign bus.dump_addr     = dump_addr;
  assign bus.dump_data     = dump_data;
  assign bus.dump_done     = dump_done;
  assign bus.mem_address   = mem_address;
  assign bus.mem_writeData = mem_writeData;
  assign bus.mem_memWrite  = mem_memWrite;
  assign bus.mem_memRead   = mem_memRead;

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Testbench for dmem_dump_arbiter: a behavioural dmem plus a reference word
// array that records what memory must hold; dumps are compared word by word
// against it under several dump_ready patterns, with random CPU traffic
// during scans.
module tb_dmem_dump_arbiter;
  localparam int N     = 64;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_dump_arbiter_if #(.N(N), .AW(AW)) bus();

  dmem_dump_arbiter #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural dmem: combinational read, write on the rising edge
  logic [N-1:0] dmem [DEPTH];
  assign bus.mem_readData = dmem[bus.mem_address];
  always @(posedge clk) begin
    if (bus.mem_memWrite)
      dmem[bus.mem_address] <= bus.mem_writeData;
  end

  // Reference contents: what dmem must hold after the accesses that should land
  logic [N-1:0] ref_mem [DEPTH];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] d, input logic we, input logic re);
    bus.cpu_addr        = a;
    bus.cpu_writeData   = d;
    bus.cpu_writeEnable = we;
    bus.cpu_readEnable  = re;
  endtask

  task automatic cpu_store(input logic [N-1:0] a, input logic [N-1:0] d);
    @(negedge clk);
    drive(a, d, 1'b1, 1'b0);
    bus.dump_req   = 1'b0;
    bus.dump_ready = 1'b0;
    ref_mem[a[AW+2:3]] = d;
  endtask

  task automatic cpu_load_chk(input logic [N-1:0] a, input string tag);
    logic [AW-1:0] w;
    w = a[AW+2:3];
    @(negedge clk);
    drive(a, '0, 1'b0, 1'b1);
    #1;
    chk(tag, bus.cpu_readData, ref_mem[w]);
    chk({tag, "_stall"}, bus.cpu_stall, 1'b0);
  endtask

  // mode: 0 = dump_ready always high, 1 = toggling starting low, 2 = random
  task automatic run_dump(input int mode, input bit coll, input logic [N-1:0] caddr,
                          input logic [N-1:0] cdata, input bit hold, input int abort_at,
                          input int exp_cycles);
    int idx;
    int cyc;
    bit rdy;
    logic [AW-1:0] cw;
    // request edge cycle: CPU still owns the port
    @(negedge clk);
    bus.dump_req   = 1'b1;
    bus.dump_ready = 1'b0;
    drive(caddr, cdata, coll, 1'b0);
    #1;
    chk("edge_stall", bus.cpu_stall, 1'b0);
    chk("edge_valid", bus.dump_valid, 1'b0);
    chk("edge_memwr", bus.mem_memWrite, coll);
    if (coll) begin
      cw = caddr[AW+2:3];
      ref_mem[cw] = cdata;
    end
    idx = 0;
    cyc = 0;
    while (idx < DEPTH && cyc < 4 * DEPTH + 8) begin
      @(negedge clk);
      if (abort_at >= 0 && idx == abort_at) break;
      bus.dump_req = hold;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 1);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.dump_ready = rdy;
      drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      #1;
      chk("scan_stall", bus.cpu_stall, 1'b1);
      chk("scan_valid", bus.dump_valid, 1'b1);
      chk("scan_addr", bus.dump_addr, idx);
      chk("scan_data", bus.dump_data, ref_mem[idx]);
      chk("scan_memwr", bus.mem_memWrite, 1'b0);
      chk("scan_memrd", bus.mem_memRead, 1'b1);
      chk("scan_done", bus.dump_done, 1'b0);
      if (rdy) idx++;
      cyc++;
    end
    if (abort_at >= 0) begin
      reset = 1'b0;
      #1;
      chk("abort_stall", bus.cpu_stall, 1'b0);
      chk("abort_valid", bus.dump_valid, 1'b0);
      chk("abort_done", bus.dump_done, 1'b0);
      chk("abort_memrd", bus.mem_memRead, 1'b0);
      chk("abort_rdata", bus.cpu_readData, ref_mem[0]);
      drive('0, '0, 1'b0, 1'b0);
      bus.dump_req   = 1'b0;
      bus.dump_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_idle_stall", bus.cpu_stall, 1'b0);
      chk("abort_idle_valid", bus.dump_valid, 1'b0);
      @(negedge clk);
      #1;
      chk("abort_no_done", bus.dump_done, 1'b0);
      chk("abort_no_stall", bus.cpu_stall, 1'b0);
      return;
    end
    chk("scan_xfers", idx, DEPTH);
    if (exp_cycles > 0) chk("scan_cycles", cyc, exp_cycles);
    // DONE cycle
    @(negedge clk);
    bus.dump_req   = hold;
    bus.dump_ready = 1'($urandom_range(0, 1));
    #1;
    chk("done_pulse", bus.dump_done, 1'b1);
    chk("done_stall", bus.cpu_stall, 1'b1);
    chk("done_valid", bus.dump_valid, 1'b0);
    chk("done_memwr", bus.mem_memWrite, 1'b0);
    chk("done_memrd", bus.mem_memRead, 1'b0);
    // back to the CPU
    @(negedge clk);
    bus.dump_req = hold;
    drive('0, '0, 1'b0, 1'b0);
    #1;
    chk("post_done", bus.dump_done, 1'b0);
    chk("post_stall", bus.cpu_stall, 1'b0);
    chk("post_valid", bus.dump_valid, 1'b0);
    if (hold) begin
      repeat (3) begin
        @(negedge clk);
        #1;
        chk("hold_no_rescan", bus.cpu_stall, 1'b0);
        chk("hold_no_valid", bus.dump_valid, 1'b0);
      end
    end
    bus.dump_req = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    bus.dump_req   = 1'b0;
    bus.dump_ready = 1'b1;
    drive(64'h18, 64'hDEADBEEF, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", bus.cpu_stall, 1'b0);
    chk("rst_valid", bus.dump_valid, 1'b0);
    chk("rst_done", bus.dump_done, 1'b0);
    chk("rst_memwr", bus.mem_memWrite, 1'b0);
    chk("rst_memrd", bus.mem_memRead, 1'b0);
    chk("rst_maddr", bus.mem_address, 0);
    chk("rst_mwdata", bus.mem_writeData, 0);
    chk("rst_daddr", bus.dump_addr, 0);
    chk("rst_ddata", bus.dump_data, 0);
`ifdef DMEM_ARB_ALIGN_CHK_EN
    chk("rst_align_err", bus.align_err, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b1;
    bus.dump_ready = 1'b0;
    drive('0, '0, 1'b0, 1'b0);

    // pass-through store and load
    @(negedge clk);
    drive(64'h18, 64'hDEADBEEF, 1'b1, 1'b0);
    #1;
    chk("pt_maddr", bus.mem_address, 3);
    chk("pt_memwr", bus.mem_memWrite, 1'b1);
    chk("pt_wdata", bus.mem_writeData, 64'hDEADBEEF);
    chk("pt_stall", bus.cpu_stall, 1'b0);
    ref_mem[3] = 64'hDEADBEEF;
    cpu_load_chk(64'h18, "pt_load");

    // full dump of word i = i*3 with dump_ready held high
    for (int i = 0; i < DEPTH; i++) cpu_store(64'(i * 8), 64'(i * 3));
    run_dump(0, 1'b0, '0, '0, 1'b0, -1, DEPTH);

    // backpressure with random contents
    for (int i = 0; i < DEPTH; i++) cpu_store(64'(i * 8), {$urandom, $urandom});
    run_dump(1, 1'b0, '0, '0, 1'b0, -1, 2 * DEPTH);

    // store in the request cycle lands before the scan reads it
    run_dump(0, 1'b1, 64'h08, 64'h55, 1'b0, -1, DEPTH);

    // random backpressure
    run_dump(2, 1'b0, '0, '0, 1'b0, -1, 0);

    // reset at dump_addr 20, then a fresh scan from address 0
    run_dump(0, 1'b0, '0, '0, 1'b0, 20, 0);
    run_dump(2, 1'b0, '0, '0, 1'b0, -1, 0);

    // dump_req held high through DONE must not retrigger
    run_dump(0, 1'b0, '0, '0, 1'b1, -1, DEPTH);

    // memory untouched by CPU traffic during scans
    for (int k = 0; k < 8; k++) cpu_load_chk({55'd0, 6'($urandom_range(0, DEPTH - 1)), 3'd0}, "final_load");

`ifdef DMEM_ARB_ALIGN_CHK_EN
    @(negedge clk);
    drive(64'h0C, 64'hA5A5, 1'b1, 1'b0);
    #1;
    chk("al_memwr", bus.mem_memWrite, 1'b0);
    chk("al_err_pre", bus.align_err, 1'b0);
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);
    #1;
    chk("al_err", bus.align_err, 1'b1);
    cpu_load_chk(64'h08, "al_word1");
    @(negedge clk);
    drive(64'h0C, '0, 1'b0, 1'b1);
    #1;
    chk("al_load_zero", bus.cpu_readData, 0);
    @(negedge clk);
    drive(64'(DEPTH * 8), '0, 1'b0, 1'b1);
    #1;
    chk("al_range_zero", bus.cpu_readData, 0);
    chk("al_err_sticky", bus.align_err, 1'b1);
`else
    @(negedge clk);
    drive(64'h0C, 64'hA5A5, 1'b1, 1'b0);
    #1;
    chk("nal_maddr", bus.mem_address, 1);
    chk("nal_memwr", bus.mem_memWrite, 1'b1);
    ref_mem[1] = 64'hA5A5;
    cpu_load_chk(64'h08, "nal_word1");
`endif
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_dump_arbiter.md
Name: dmem_dump_arbiter

Overview:
Arbitrates the single data-memory port between the pipeline MEM stage and a sequential memory-dump scanner. In normal operation the block passes CPU accesses through unchanged. On a dump request it stalls the pipeline, streams every data-memory word out over a valid/ready handshake, then returns the port to the CPU. It sits between the datapath DM_* signals and dmem and replaces the direct dump wire into dmem.

Parameters:
N, 64, data word width
AW, 6, word-address width (dmem word index = byte address [AW+2:3])
DEPTH, 64, number of words scanned (must be <= 2**AW)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_addr  in  N  CPU byte address (DM_addr)
cpu_writeData  in  N  CPU store data
cpu_writeEnable  in  1  CPU store strobe
cpu_readEnable  in  1  CPU load strobe
cpu_readData  out  N  load data returned to datapath
cpu_stall  out  1  freezes PC and pipeline registers while high
dump_req  in  1  dump request; rising edge starts a scan
dump_ready  in  1  consumer accepts the current dump word
dump_valid  out  1  dump_data/dump_addr valid
dump_addr  out  AW  word index of current dump word
dump_data  out  N  current dump word
dump_done  out  1  one-cycle pulse after the last word is accepted
mem_address  out  AW  dmem word address
mem_writeData  out  N  dmem write data
mem_memWrite  out  1  dmem write enable
mem_memRead  out  1  dmem read enable
mem_readData  in  N  dmem read data (combinational read, same cycle)

Behaviour:
- Reset (reset=0, async): state IDLE, scan counter 0, dump_req edge register 0. All outputs 0, except cpu_readData, which follows mem_readData.
- States: IDLE, SCAN, DONE.
- IDLE: CPU pass-through. mem_address = cpu_addr[AW+2:3]; mem_writeData, mem_memWrite and mem_memRead come from the CPU inputs. cpu_stall=0, dump_valid=0.
- IDLE -> SCAN: on a dump_req rising edge (dump_req=1 and registered dump_req=0). The CPU access presented in that same cycle completes normally; the CPU has priority for that one cycle. cpu_stall rises in the next cycle.
- SCAN:
  - cpu_stall=1, mem_memWrite=0, mem_memRead=1.
  - mem_address = counter, dump_addr = counter, dump_data = mem_readData, dump_valid=1.
  - CPU write/read strobes are ignored and never reach dmem.
- Scan handshake: a transfer occurs when dump_valid & dump_ready. Counter increments by 1 per transfer. dump_ready low holds counter and data stable, with no time limit.
- SCAN -> DONE: on the transfer where counter == DEPTH-1. Counter wraps to 0.
- DONE: lasts exactly one cycle. dump_done=1, cpu_stall=1, dump_valid=0, memory idle. Next state IDLE, where cpu_stall=0.
- Re-arm: dump_req must return low before a new scan can start. A level held high through DONE does not retrigger.
- dump_req edges during SCAN or DONE are ignored.
- Reset mid-scan: scan is aborted immediately, with no dump_done. The counter value is discarded.
- Latency:
  - Request edge to first dump_valid: 1 cycle.
  - Minimum scan: DEPTH cycles with dump_ready held high.
  - Total stall: DEPTH+1 cycles (SCAN + DONE).

Optional Feature:
Macro DMEM_ARB_ALIGN_CHK_EN.
- Defined:
  - Adds output align_err (1 bit, sticky, cleared only by reset).
  - In IDLE, a CPU access with cpu_addr[2:0] != 0, or with cpu_addr above the DEPTH*8-1 range, sets align_err.
  - A store that fails this check is suppressed: mem_memWrite=0.
  - A load that fails this check returns 0 on cpu_readData.
- Not defined: port align_err is absent. Address bits [2:0] and bits above AW+2 are ignored; all accesses pass through.

Test Plan:
- Pass-through: in IDLE, store 0xDEADBEEF at cpu_addr 0x18 -> mem_address=3, mem_memWrite=1; a following load of 0x18 -> cpu_readData=0xDEADBEEF, cpu_stall=0.
- Full dump: preload word i = i*3, pulse dump_req, dump_ready=1 -> cpu_stall high next cycle; 64 transfers with dump_addr 0..63 and data 0..189; dump_done for 1 cycle; cpu_stall low after 65 stall cycles.
- Backpressure: toggle dump_ready 1/0 every cycle -> each word transferred exactly once in order; dump_addr stable while dump_ready=0; scan lasts 128 cycles.
- Collision: store 0x55 to 0x08 in the same cycle dump_req rises -> store lands; dump word 1 = 0x55; CPU writes during SCAN do not modify dmem.
- Reset mid-scan: assert reset at dump_addr=20 -> next sampled state IDLE, dump_valid=0, cpu_stall=0, no dump_done. A new dump_req edge restarts from address 0.
- Re-arm/option: hold dump_req high through DONE -> no second scan. With DMEM_ARB_ALIGN_CHK_EN, a store to 0x0C -> align_err=1, dmem unchanged.
